sort_result_collector: RTL and testbench

Receiving end of the bubble-sort stream interface. It captures the serial sorted word stream produced by the sort FSM into a local buffer and checks on the fly that the stream is non-increasing (descending, equal values allowed). It then replays the captured words to a downstream reader over a valid/ready handshake. It sits between the sorter's output port and any consumer, such as the result memory or the bench scoreboard.

---
 rtl/sort_pkg.sv | 16 +
 rtl/sort_collector_buf.sv | 23 ++
 rtl/sort_result_collector.sv | 129 ++++++++++++
 tb/tb_sort_result_collector.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Types and default sizes shared by the bubble-sort FSM and its result collector.
package sort_pkg;

  localparam int SORT_WIDTH = 32;
  localparam int SORT_DEPTH = 64;

  typedef logic [SORT_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/sort_collector_buf.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module sort_collector_buf #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sort_result_collector.sv
// Captures the sorter's descending word stream, flags ordering violations, then replays it over valid/ready.
// Optional SORT_COLLECTOR_CHECKSUM_EN adds a running sum of captured words on the checksum port.
module sort_result_collector
  import sort_pkg::*;
#(
  parameter  int WIDTH = SORT_WIDTH,
  parameter  int DEPTH = SORT_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             order_err,
  output logic             ovf_err,
  output logic [CW-1:0]    count
`ifdef SORT_COLLECTOR_CHECKSUM_EN
  ,
  output logic [WIDTH+AW-1:0] checksum
`endif
);

  state_t           state_q, state_d;
  logic [CW-1:0]    len_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    rd_ptr_q;
  logic [WIDTH-1:0] prev_q;
  logic             order_err_q;
  logic             ovf_err_q;
  logic [WIDTH-1:0] rd_data;

  logic             n_over;
  logic [CW-1:0]    n_len;
  logic             accept_start;
  logic             wr_en;
  logic             xfer;

  // n is judged at full 32 bits before clamping so large values cannot alias into range
  assign n_over       = (n > 32'(DEPTH));
  assign n_len        = n_over ? CW'(DEPTH) : n[CW-1:0];
  assign accept_start = (state_q == IDLE) && start;
  assign wr_en        = (state_q == CAPTURE) && in_valid;
  assign xfer         = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (n_len == '0) ? DONE : CAPTURE;
      CAPTURE: if (wr_en && ((count_q + CW'(1)) == len_q)) state_d = DRAIN;
      DRAIN:   if (xfer && (rd_ptr_q == (count_q - CW'(1)))) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      prev_q      <= '0;
      order_err_q <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_start) begin
        len_q       <= n_len;
        ovf_err_q   <= n_over;
        count_q     <= '0;
        rd_ptr_q    <= '0;
        order_err_q <= 1'b0;
      end
      if (wr_en) begin
        count_q <= count_q + CW'(1);
        prev_q  <= in_data;
        // the first word of a job has no predecessor to compare against
        if ((count_q != '0) && (in_data > prev_q)) order_err_q <= 1'b1;
      end
      if (xfer) rd_ptr_q <= rd_ptr_q + CW'(1);
    end
  end

  sort_collector_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (count_q[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_data)
  );

  // the buffer is never reset, so mask its read port while nothing is being offered
  assign out_valid = (state_q == DRAIN) && (rd_ptr_q < count_q);
  assign out_data  = out_valid ? rd_data : '0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign order_err = order_err_q;
  assign ovf_err   = ovf_err_q;
  assign count     = count_q;

`ifdef SORT_COLLECTOR_CHECKSUM_EN
  logic [WIDTH+AW-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else if (accept_start) begin
      sum_q <= '0;
    end else if (wr_en) begin
      sum_q <= sum_q + (WIDTH+AW)'(in_data);
    end
  end

  assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_sort_result_collector.sv
// Directed bench for sort_result_collector at WIDTH=32, DEPTH=64.
module tb_sort_result_collector;

  typedef logic [31:0] wq_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] n;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        order_err;
  logic        ovf_err;
  logic [6:0]  count;
`ifdef SORT_COLLECTOR_CHECKSUM_EN
  logic [37:0] checksum;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  sort_result_collector #(.WIDTH(32), .DEPTH(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .n         (n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .order_err (order_err),
    .ovf_err   (ovf_err),
    .count     (count)
`ifdef SORT_COLLECTOR_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [31:0] nv);
    n     = nv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_words(input wq_t q);
    foreach (q[i]) begin
      in_valid = 1'b1;
      in_data  = q[i];
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Drains the replay; returns at the cycle where done is high.
  task automatic collect(input string tag, input wq_t exp, input bit toggle, output int vcycles);
    bit          pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int          idx = 0;
    int          last = -10;
    bit          seen = 1'b0;
    bit          stalled = 1'b0;
    logic [31:0] held = '0;
    vcycles = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      out_ready = toggle ? pat[i % 5] : 1'b1;
      if (done) begin
        seen = 1'b1;
        check({tag, "_done_lag"}, 64'(i - last), 64'd1);
        check({tag, "_xfers"}, 64'(idx), 64'(exp.size()));
        check({tag, "_valid_at_done"}, 64'(out_valid), 64'd0);
      end else if (out_valid) begin
        vcycles++;
        if (stalled) check($sformatf("%s_hold%0d", tag, idx), 64'(out_data), 64'(held));
        if (idx < exp.size()) check($sformatf("%s_data%0d", tag, idx), 64'(out_data), 64'(exp[idx]));
        else check({tag, "_extra_valid"}, 64'(out_valid), 64'd0);
        stalled = !out_ready;
        held    = out_data;
        if (out_ready) begin
          idx++;
          last = i;
        end
      end
      if (!seen) tick();
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    wq_t q;
    int  vc;

    reset = 1'b1; n = '0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_order_err", 64'(order_err), 64'd0);
    check("rst_ovf_err", 64'(ovf_err), 64'd0);
    check("rst_count", 64'(count), 64'd0);

    // Scenario 1: clean descending stream with ties, reader always ready
    start_job(32'd5);
    check("s1_busy", 64'(busy), 64'd1);
    q = '{32'd90, 32'd70, 32'd70, 32'd20, 32'd3};
    send_words(q);
    check("s1_valid_after_last", 64'(out_valid), 64'd1);
    collect("s1", q, 1'b0, vc);
    check("s1_valid_cycles", 64'(vc), 64'd5);
    check("s1_order_err", 64'(order_err), 64'd0);
    check("s1_count", 64'(count), 64'd5);
`ifdef SORT_COLLECTOR_CHECKSUM_EN
    check("s1_checksum", 64'(checksum), 64'd253);
`endif
    tick();
    check("s1_done_one_cycle", 64'(done), 64'd0);
    check("s1_idle", 64'(busy), 64'd0);
    check("s1_count_holds", 64'(count), 64'd5);

    // Scenario 2: 40 after 10 breaks the ordering
    start_job(32'd4);
    in_valid = 1'b1;
    in_data  = 32'd10; tick();
    check("s2_err_after_10", 64'(order_err), 64'd0);
    in_data  = 32'd40; tick();
    check("s2_err_after_40", 64'(order_err), 64'd1);
    in_data  = 32'd30; tick();
    in_data  = 32'd5;  tick();
    in_valid = 1'b0;
    check("s2_err_sticky", 64'(order_err), 64'd1);
    q = '{32'd10, 32'd40, 32'd30, 32'd5};
    collect("s2", q, 1'b0, vc);
    check("s2_err_at_done", 64'(order_err), 64'd1);
    tick();

    // Scenario 3: reader stalls with ready pattern 1,0,0,1,1
    start_job(32'd3);
    check("s3_err_cleared", 64'(order_err), 64'd0);
    q = '{32'd9, 32'd6, 32'd2};
    send_words(q);
    collect("s3", q, 1'b1, vc);
    check("s3_count", 64'(count), 64'd3);
    tick();

    // Scenario 4: n=70 clamps to 64 words
    start_job(32'd70);
    check("s4_ovf", 64'(ovf_err), 64'd1);
    q = {};
    for (int i = 0; i < 64; i++) q.push_back(32'(1000 - 3 * i));
    send_words(q);
    collect("s4", q, 1'b0, vc);
    check("s4_count", 64'(count), 64'd64);
    check("s4_ovf_at_done", 64'(ovf_err), 64'd1);
    tick();

    // Scenario 5: empty job
    start_job(32'd0);
    check("s5_busy", 64'(busy), 64'd1);
    check("s5_done", 64'(done), 64'd1);
    check("s5_valid", 64'(out_valid), 64'd0);
    check("s5_ovf_cleared", 64'(ovf_err), 64'd0);
    check("s5_count", 64'(count), 64'd0);
    tick();
    check("s5_busy_gone", 64'(busy), 64'd0);
    check("s5_done_gone", 64'(done), 64'd0);
    check("s5_valid_after", 64'(out_valid), 64'd0);

    // Scenario 6: reset aborts a job partway through capture
    start_job(32'd5);
    q = '{32'd90, 32'd70};
    send_words(q);
    check("s6_count_mid", 64'(count), 64'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("s6_busy", 64'(busy), 64'd0);
    check("s6_count", 64'(count), 64'd0);
    check("s6_valid", 64'(out_valid), 64'd0);
    check("s6_data", 64'(out_data), 64'd0);
    check("s6_done", 64'(done), 64'd0);
    start_job(32'd2);
    q = '{32'd8, 32'd1};
    send_words(q);
    collect("s6", q, 1'b0, vc);
    check("s6_order_err", 64'(order_err), 64'd0);
    check("s6_ovf_err", 64'(ovf_err), 64'd0);
    check("s6_count_final", 64'(count), 64'd2);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
